io_word_assembler: RTL and testbench
====================================

IO_WORD_ASSEMBLER -- requirements
Module: io_word_assembler

Interface
REQ-001 Parameter DROP_CNT_W SHALL be: DROP_CNT_W, 8, width of the saturating dropped-packet counter.
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be: reset  input  1  synchronous, active-high reset.
REQ-004 Port in_valid SHALL be: in_valid  input  1  byte on in_data is valid this cycle.
REQ-005 Port in_data SHALL be: in_data  input  8  incoming byte stream.
REQ-006 Port in_ready SHALL be: in_ready  output  1  block accepts a byte this cycle.
REQ-007 Port done SHALL be: done  input  1  downstream memory manager has finished writing the held words.
REQ-008 Port store1 SHALL be: store1  output  1  temp1 holds a complete word to be written.
REQ-009 Port store2 SHALL be: store2  output  1  temp2 holds a complete word to be written.
REQ-010 Port temp1 SHALL be: temp1  output  32  assembled word 1.
REQ-011 Port temp2 SHALL be: temp2  output  32  assembled word 2.
REQ-012 Port drop_count SHALL be: drop_count  output  DROP_CNT_W  number of dropped packets, saturating.

Function
REQ-013 A byte SHALL be accepted only on a rising clk edge where in_valid=1 and in_ready=1.
REQ-014 Packet format SHALL be: 1 tag byte, then 4 bytes of word 1 if tag[0]=1, then 4 bytes of word 2 if tag[1]=1; tag[7:2] is ignored.
REQ-015 Payload bytes SHALL be little-endian: the first byte goes to bits[7:0] and the fourth byte to bits[31:24].
REQ-016 States SHALL be IDLE, W1, W2 and HOLD; in_ready SHALL be 1 in IDLE, W1 and W2, and 0 in HOLD (decoded combinationally from state).
REQ-017 IDLE, tag accepted with tag[1:0]=00: stay in IDLE and increment drop_count, saturating at all-ones.
REQ-018 IDLE, tag accepted with tag[0]=1: go to W1 and latch tag[1:0].
REQ-019 IDLE, tag accepted with tag[1:0]=10: go to W2 and latch tag[1:0].
REQ-020 IDLE, tag accepted with any nonzero tag: clear the byte counter.
REQ-021 W1: after the 4th accepted byte, go to W2 if tag[1]=1, otherwise go to HOLD.
REQ-022 W2: after the 4th accepted byte, go to HOLD.
REQ-023 The byte counter SHALL be 2 bits, wrap from 3 to 0, and advance only on accepted bytes; in_valid=0 cycles SHALL stall assembly indefinitely with no timeout.
REQ-024 store1 and store2 SHALL be registered and SHALL rise on the same edge that enters HOLD, equal to latched tag[0] and tag[1] respectively.
REQ-025 temp1 and temp2 SHALL be stable for the whole time they are in HOLD.
REQ-026 HOLD: on an edge where done=1, go to IDLE and clear store1 and store2 on that same edge; in_ready SHALL be 1 in the following cycle.
REQ-027 temp1 and temp2 SHALL keep their last values after HOLD exits and SHALL only be overwritten byte-by-byte by a later packet.
REQ-028 A word not present in a packet SHALL leave its temp register unchanged.
REQ-029 done SHALL be ignored in IDLE, W1 and W2.
REQ-030 in_valid and in_data SHALL be ignored in HOLD, because in_ready=0.
REQ-031 Latency: store goes high on the edge that accepts the last payload byte, with no extra cycle.
REQ-032 Minimum packet-to-packet spacing SHALL be 1 cycle in HOLD when done=1 is asserted immediately.

Reset
REQ-033 On an edge where reset=1, the block SHALL enter IDLE and set store1=0, store2=0, temp1=0, temp2=0, drop_count=0 and the byte counter to 0.
REQ-034 in_ready SHALL be 1 in the cycle after reset is released.
REQ-035 reset SHALL take priority over in_valid and done on the same edge.
REQ-036 Reset in the middle of a packet SHALL discard the partial word; the next accepted byte SHALL be treated as a tag.

Verification
REQ-037 Full packet: send tag 0x03, bytes 11 22 33 44 55 66 77 88 -> temp1=0x44332211, temp2=0x88776655, store1=1, store2=1, in_ready=0, all until done is pulsed.
REQ-038 Word 2 only: send tag 0x02, bytes AA BB CC DD -> store1=0, store2=1, temp2=0xDDCCBBAA, temp1 unchanged; done=1 -> stores drop to 0 on that edge and in_ready=1 in the next cycle.
REQ-039 Drop and saturate: with DROP_CNT_W=2, send 5 tag bytes of 0x00 -> drop_count goes 1,2,3,3,3, state stays IDLE and store1=store2=0.
REQ-040 Stall and back-pressure: tag 0x01 with in_valid gaps between bytes -> temp1 still correct; in_valid=1 bytes offered in HOLD are not consumed, and the first byte after done is taken as a tag.
REQ-041 Reset mid-packet: tag 0x03 plus 3 bytes, then reset=1 for one edge -> all outputs are 0, in_ready=1, and the next packet 0x01 01 02 03 04 gives temp1=0x04030201 with store1=1.
REQ-042 done outside HOLD: pulse done in IDLE and in W1 -> no change in state, in store1/store2, or in byte acceptance.

Source files
------------

// File: rtl/io_word_assembler_if.sv
// Byte-stream and held-word bundle between the byte source, the word assembler
// and the downstream memory manager.
interface io_word_assembler_if #(
    parameter int DROP_CNT_W = 8
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  done;
    logic                  store1;
    logic                  store2;
    logic [31:0]           temp1;
    logic [31:0]           temp2;
    logic [DROP_CNT_W-1:0] drop_count;

    modport master (
        output in_valid, in_data, done,
        input  in_ready, store1, store2, temp1, temp2, drop_count
    );

    modport slave (
        input  in_valid, in_data, done,
        output in_ready, store1, store2, temp1, temp2, drop_count
    );
endinterface

// File: rtl/io_word_assembler.sv
// Assembles tagged byte packets into up to two little-endian 32-bit words and
// holds them until the downstream memory manager signals done.
module io_word_assembler #(
    parameter int DROP_CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    io_word_assembler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, W1, W2, HOLD} state_t;

    state_t                state, state_nxt;
    logic [1:0]            byte_cnt;
    logic [1:0]            tag;
    logic                  rdy;
    logic                  accept;
    logic                  last_byte;
    logic                  s1, s2;
    logic [31:0]           t1, t2;
    logic [DROP_CNT_W-1:0] drop_cnt;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        if (v == {DROP_CNT_W{1'b1}})
            return v;
        return v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign accept    = bus.in_valid && rdy;
    assign last_byte = accept && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.in_data[0])
                        state_nxt = W1;
                    else if (bus.in_data[1])
                        state_nxt = W2;
                end
            end
            W1:      if (last_byte) state_nxt = tag[1] ? W2 : HOLD;
            W2:      if (last_byte) state_nxt = HOLD;
            HOLD:    if (bus.done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdy = (state != HOLD);
    end

    // Stores are set from the latched tag on the same edge that enters HOLD,
    // so the downstream sees them with no added latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= 2'd0;
            tag      <= 2'd0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            t1       <= 32'd0;
            t2       <= 32'd0;
            drop_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.in_data[1:0] == 2'b00) begin
                            drop_cnt <= sat_inc(drop_cnt);
                        end else begin
                            tag      <= bus.in_data[1:0];
                            byte_cnt <= 2'd0;
                        end
                    end
                end
                W1: begin
                    if (accept) begin
                        t1[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte && !tag[1]) begin
                            s1 <= tag[0];
                            s2 <= tag[1];
                        end
                    end
                end
                W2: begin
                    if (accept) begin
                        t2[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            s1 <= tag[0];
                            s2 <= tag[1];
                        end
                    end
                end
                HOLD: begin
                    if (bus.done) begin
                        s1 <= 1'b0;
                        s2 <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = rdy;
    assign bus.store1     = s1;
    assign bus.store2     = s2;
    assign bus.temp1      = t1;
    assign bus.temp2      = t2;
    assign bus.drop_count = drop_cnt;
endmodule

// File: tb/tb_io_word_assembler.sv
// Directed bench for io_word_assembler: expected held words are queued when a
// packet is sent and checked when the block raises its store flags.
module tb_io_word_assembler;
    localparam int DW = 2;

    typedef struct {
        logic [31:0] t1;
        logic [31:0] t2;
        logic        s1;
        logic        s2;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mism = 0;
    exp_t sb[$];
    logic [31:0] m_t1 = 32'd0;
    logic [31:0] m_t2 = 32'd0;

    io_word_assembler_if #(.DROP_CNT_W(DW)) bus ();
    io_word_assembler #(.DROP_CNT_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        logic rdy;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 50; i++) begin
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        chk("accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8]);
    endtask

    task automatic push_pkt(input logic [7:0] tg, input logic [31:0] w1, input logic [31:0] w2);
        if (tg[0]) m_t1 = w1;
        if (tg[1]) m_t2 = w2;
        sb.push_back('{m_t1, m_t2, tg[0], tg[1]});
    endtask

    task automatic expect_out(input string tag);
        exp_t e;
        chk({tag, " sb_nonempty"}, {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " temp1"},    bus.temp1, e.t1);
            chk({tag, " temp2"},    bus.temp2, e.t2);
            chk({tag, " store1"},   {31'd0, bus.store1}, {31'd0, e.s1});
            chk({tag, " store2"},   {31'd0, bus.store2}, {31'd0, e.s2});
            chk({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        end
    endtask

    task automatic pulse_done(input string tag);
        bus.done = 1'b1;
        idle(1);
        bus.done = 1'b0;
        chk({tag, " store1_clr"}, {31'd0, bus.store1}, 32'd0);
        chk({tag, " store2_clr"}, {31'd0, bus.store2}, 32'd0);
        chk({tag, " ready_after"}, {31'd0, bus.in_ready}, 32'd1);
        chk({tag, " temp1_kept"}, bus.temp1, m_t1);
        chk({tag, " temp2_kept"}, bus.temp2, m_t2);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.done     = 1'b0;
        reset        = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("rst store1", {31'd0, bus.store1}, 32'd0);
        chk("rst store2", {31'd0, bus.store2}, 32'd0);
        chk("rst temp1", bus.temp1, 32'd0);
        chk("rst temp2", bus.temp2, 32'd0);
        chk("rst drop", {30'd0, bus.drop_count}, 32'd0);
        chk("rst ready", {31'd0, bus.in_ready}, 32'd1);

        // Full two-word packet, then hold for a while before done.
        push_pkt(8'h03, 32'h44332211, 32'h88776655);
        send_byte(8'h03);
        send_word(32'h44332211);
        send_word(32'h88776655);
        sb.push_back('{m_t1, m_t2, 1'b1, 1'b1});
        expect_out("full");
        idle(3);
        expect_out("full_held");
        pulse_done("full");

        // Word 2 only; temp1 must stay as before.
        push_pkt(8'h02, 32'h0, 32'hDDCCBBAA);
        send_byte(8'h02);
        send_word(32'hDDCCBBAA);
        expect_out("w2only");
        pulse_done("w2only");

        // Empty tags are dropped and the counter saturates.
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h00);
            chk("drop count", {30'd0, bus.drop_count}, (i < 3) ? i + 1 : 3);
            chk("drop ready", {31'd0, bus.in_ready}, 32'd1);
            chk("drop stores", {30'd0, bus.store1, bus.store2}, 32'd0);
        end

        // Word 1 with valid gaps between bytes.
        push_pkt(8'h01, 32'hCAFE5A0F, 32'h0);
        send_byte(8'h01);
        idle(2);
        send_byte(8'h0F); idle(1);
        send_byte(8'h5A); idle(3);
        send_byte(8'hFE); idle(2);
        send_byte(8'hCA);
        expect_out("stall");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h02;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("hold ready", {31'd0, bus.in_ready}, 32'd0);
            chk("hold temp1", bus.temp1, m_t1);
            chk("hold store1", {31'd0, bus.store1}, 32'd1);
        end
        bus.done = 1'b1;
        idle(1);
        bus.done = 1'b0;
        chk("hold exit ready", {31'd0, bus.in_ready}, 32'd1);
        chk("hold exit store1", {31'd0, bus.store1}, 32'd0);
        push_pkt(8'h02, 32'h0, 32'h04030201);
        send_byte(8'h02);
        send_word(32'h04030201);
        expect_out("after_hold");
        pulse_done("after_hold");

        // Reset in the middle of a packet.
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        m_t1 = 32'd0;
        m_t2 = 32'd0;
        chk("midrst temp1", bus.temp1, 32'd0);
        chk("midrst temp2", bus.temp2, 32'd0);
        chk("midrst stores", {30'd0, bus.store1, bus.store2}, 32'd0);
        chk("midrst drop", {30'd0, bus.drop_count}, 32'd0);
        chk("midrst ready", {31'd0, bus.in_ready}, 32'd1);
        push_pkt(8'h01, 32'h04030201, 32'h0);
        send_byte(8'h01);
        send_word(32'h04030201);
        expect_out("midrst");
        pulse_done("midrst");

        // done outside HOLD has no effect.
        bus.done = 1'b1;
        idle(2);
        bus.done = 1'b0;
        chk("done idle ready", {31'd0, bus.in_ready}, 32'd1);
        chk("done idle stores", {30'd0, bus.store1, bus.store2}, 32'd0);
        push_pkt(8'h01, 32'h7788AABB, 32'h0);
        send_byte(8'h01);
        send_byte(8'hBB);
        send_byte(8'hAA);
        bus.done = 1'b1;
        send_byte(8'h88);
        bus.done = 1'b0;
        chk("done w1 ready", {31'd0, bus.in_ready}, 32'd1);
        chk("done w1 stores", {30'd0, bus.store1, bus.store2}, 32'd0);
        send_byte(8'h77);
        expect_out("done_w1");
        pulse_done("done_w1");

        chk("sb drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
